// File: rtl/immgen_if.sv
// Handshake bundle for the ID-stage immediate generator: request side
// (decode -> generator) and result side (generator -> ID/EX register).
interface immgen_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [24:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  // Environment side: drives requests and result acceptance.
  modport master (
    output in_valid, in_sel, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag, out_illegal
  );

  // Generator side.
  modport slave (
    input  in_valid, in_sel, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag, out_illegal
  );
endinterface

// File: rtl/immgen_pipe.sv
// Registered RV32/RV64 immediate generator with a 2-entry skid buffer so that
// in_ready never depends combinationally on out_ready.
module immgen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  immgen_if.slave bus
);

  typedef enum logic [2:0] {
    SEL_I     = 3'd0,
    SEL_S     = 3'd1,
    SEL_SB    = 3'd2,
    SEL_UJ    = 3'd3,
    SEL_U     = 3'd4,
    SEL_Z     = 3'd5,
    SEL_SHAMT = 3'd6,
    SEL_RSVD  = 3'd7
  } sel_e;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  state_e     state_q;
  entry_t     main_q;
  entry_t     skid_q;
  entry_t     new_e;
  logic       out_valid_q;
  logic       in_ready_q;
  logic [31:7] i;
  logic       in_xfer;
  logic       out_xfer;

  // Index the instruction by its architectural bit numbers.
  assign i = bus.in_instr;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    new_e         = '0;
    new_e.tag     = bus.in_tag;
    new_e.illegal = (sel_e'(bus.in_sel) == SEL_RSVD);
    case (sel_e'(bus.in_sel))
      SEL_I:  new_e.imm = XLEN'($signed(i[31:20]));
      SEL_S:  new_e.imm = XLEN'($signed({i[31:25], i[11:7]}));
      SEL_SB: new_e.imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
      SEL_UJ: new_e.imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
      SEL_U:  new_e.imm = XLEN'($signed({i[31:12], 12'b0}));
      SEL_Z:  new_e.imm = XLEN'(i[19:15]);
      SEL_SHAMT: begin
        if (XLEN == 64) new_e.imm = XLEN'(i[25:20]);
        else            new_e.imm = XLEN'(i[24:20]);
      end
      default: new_e.imm = '0;
    endcase
  end

  assign in_xfer  = bus.in_valid && in_ready_q;
  assign out_xfer = out_valid_q && bus.out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      // NOTE: payload registers are reset too, because they drive the
      // outputs directly and must read zero during reset.
      main_q      <= '0;
      skid_q      <= '0;
    end else if (flush) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            main_q      <= new_e;
            state_q     <= ONE;
            out_valid_q <= 1'b1;
          end
        end
        ONE: begin
          if (in_xfer && !out_xfer) begin
            skid_q     <= new_e;
            state_q    <= TWO;
            in_ready_q <= 1'b0;
          end else if (out_xfer && !in_xfer) begin
            state_q     <= EMPTY;
            out_valid_q <= 1'b0;
          end else if (in_xfer && out_xfer) begin
            main_q <= new_e;
          end
        end
        TWO: begin
          // in_ready is low here, so only the drain can happen.
          if (out_xfer) begin
            main_q     <= skid_q;
            state_q    <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= EMPTY;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_imm     = main_q.imm;
  assign bus.out_tag     = main_q.tag;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: XLEN=32 and XLEN=64 instances share one
// stimulus stream; expected values are hand-computed.
module tb_immgen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [2:0]  in_sel;
  logic [24:0] in_instr;
  logic [7:0]  in_tag;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  immgen_if #(.XLEN(32), .TAG_W(8)) b32 ();
  immgen_if #(.XLEN(64), .TAG_W(8)) b64 ();

  assign b32.in_valid  = in_valid;
  assign b32.in_sel    = in_sel;
  assign b32.in_instr  = in_instr;
  assign b32.in_tag    = in_tag;
  assign b32.out_ready = out_ready;
  assign b64.in_valid  = in_valid;
  assign b64.in_sel    = in_sel;
  assign b64.in_instr  = in_instr;
  assign b64.in_tag    = in_tag;
  assign b64.out_ready = out_ready;

  immgen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (b32)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus  (b64)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // One request with out_ready=1; result is checked the following cycle.
  task automatic run_one(input string name, input logic [2:0] sel, input logic [31:0] instr,
                         input logic [63:0] e32, input logic [63:0] e64, input logic ill);
    @(negedge clk);
    in_valid  = 1'b1;
    in_sel    = sel;
    in_instr  = instr[31:7];
    in_tag    = 8'hA5;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check({name, ".valid"}, 64'(b32.out_valid), 64'd1);
    check({name, ".imm32"}, 64'(b32.out_imm), e32);
    check({name, ".imm64"}, b64.out_imm, e64);
    check({name, ".ill"}, 64'(b32.out_illegal), 64'(ill));
    check({name, ".tag"}, 64'(b32.out_tag), 64'hA5);
  endtask

  // Push one tagged I-format request while out_ready is held low.
  task automatic push(input logic [7:0] tag);
    @(negedge clk);
    in_valid = 1'b1;
    in_sel   = 3'd0;
    in_instr = 25'h1FFFFFF;
    in_tag   = tag;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 3'd0;
    in_instr  = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    #3;
    check("rst.valid", 64'(b32.out_valid), 64'd0);
    check("rst.imm", b64.out_imm, 64'd0);
    check("rst.tag", 64'(b32.out_tag), 64'd0);
    check("rst.ill", 64'(b32.out_illegal), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 64'(b32.in_ready), 64'd1);

    // Format vectors.
    run_one("I",     3'd0, 32'hFFF00093, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    run_one("S",     3'd1, 32'hFE112E23, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    run_one("SB",    3'd2, 32'hFE000EE3, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    run_one("UJ",    3'd3, 32'h0080006F, 64'h00000008, 64'h0000000000000008, 1'b0);
    run_one("U",     3'd4, 32'h123450B7, 64'h12345000, 64'h0000000012345000, 1'b0);
    run_one("Uneg",  3'd4, 32'h800000B7, 64'h80000000, 64'hFFFFFFFF80000000, 1'b0);
    run_one("Z",     3'd5, 32'h000F8073, 64'h0000001F, 64'h000000000000001F, 1'b0);
    run_one("SHAMT", 3'd6, 32'h03F00013, 64'h0000001F, 64'h000000000000003F, 1'b0);
    run_one("RSVD",  3'd7, 32'hFFFFFFFF, 64'h00000000, 64'h0000000000000000, 1'b1);

    // Drain, then backpressure with tags 1,2,3.
    @(negedge clk);
    check("drain.valid", 64'(b32.out_valid), 64'd0);
    out_ready = 1'b0;
    push(8'd1);
    @(negedge clk);
    check("bp.rdy_after1", 64'(b32.in_ready), 64'd1);
    check("bp.tag_after1", 64'(b32.out_tag), 64'd1);
    in_tag = 8'd2;
    @(negedge clk);
    check("bp.rdy_after2", 64'(b32.in_ready), 64'd0);
    check("bp.head", 64'(b32.out_tag), 64'd1);
    in_tag = 8'd3;
    @(negedge clk);
    check("bp.stall_valid", 64'(b32.out_valid), 64'd1);
    check("bp.stall_tag", 64'(b32.out_tag), 64'd1);
    check("bp.stall_imm", 64'(b32.out_imm), 64'hFFFFFFFF);
    check("bp.stall_rdy", 64'(b32.in_ready), 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp.out2", 64'(b32.out_tag), 64'd2);
    check("bp.rdy_reopen", 64'(b32.in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp.out3", 64'(b32.out_tag), 64'd3);
    check("bp.out3_valid", 64'(b32.out_valid), 64'd1);
    @(negedge clk);
    check("bp.empty", 64'(b32.out_valid), 64'd0);

    // Flush in TWO with a simultaneous request.
    out_ready = 1'b0;
    push(8'd4);
    @(negedge clk);
    in_tag = 8'd5;
    @(negedge clk);
    check("fl.two", 64'(b32.in_ready), 64'd0);
    in_tag = 8'd6;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl.valid", 64'(b32.out_valid), 64'd0);
    check("fl.rdy", 64'(b32.in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("fl.no_leak", 64'(b32.out_valid), 64'd0);

    // Flush in ONE: the accepted-looking request in the flush cycle is dropped.
    out_ready = 1'b0;
    push(8'd7);
    @(negedge clk);
    in_tag = 8'd8;
    flush  = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl1.valid", 64'(b32.out_valid), 64'd0);
    check("fl1.rdy", 64'(b32.in_ready), 64'd1);

    // Async reset while in TWO.
    push(8'd9);
    @(negedge clk);
    in_tag = 8'd10;
    @(negedge clk);
    in_valid = 1'b0;
    check("ar.two", 64'(b32.in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    check("ar.valid", 64'(b32.out_valid), 64'd0);
    check("ar.imm32", 64'(b32.out_imm), 64'd0);
    check("ar.imm64", b64.out_imm, 64'd0);
    check("ar.tag", 64'(b32.out_tag), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("ar.rdy", 64'(b32.in_ready), 64'd1);
    check("ar.valid_after", 64'(b32.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Registered, parametrised immediate generator for the ID stage.
- Accepts `instr[31:7]` plus an immediate-format select and a sideband tag through a valid/ready handshake.
- Produces the sign- or zero-extended `XLEN`-wide immediate one cycle later.
- A 2-entry skid buffer decouples upstream `in_ready` from downstream `out_ready`, so the block sits between decode and the ID/EX register without combinational ready paths.
- Adds RV64 support, CSR zimm and shift-amount formats, an illegal-select flag, and flush.

Parameters:
- `XLEN`, 32, immediate output width; legal values 32 or 64.
- `TAG_W`, 8, width of the opaque sideband tag carried alongside each immediate.

Ports:
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `flush`  input  1  synchronous kill of all buffered entries.
- `in_valid`  input  1  upstream presents a request.
- `in_ready`  output  1  block can accept a request this cycle.
- `in_sel`  input  3  format: 0 I, 1 S, 2 SB, 3 UJ, 4 U, 5 Z, 6 SHAMT, 7 reserved.
- `in_instr`  input  25  instruction bits [31:7].
- `in_tag`  input  `TAG_W`  sideband, returned unchanged.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  downstream accepts result.
- `out_imm`  output  `XLEN`  generated immediate.
- `out_tag`  output  `TAG_W`  tag of the result.
- `out_illegal`  output  1  `in_sel` was 7 for this result.

Behaviour:
- Reset (async, `rst_n`=0): both entries invalid; `out_valid`=0, `out_imm`=0, `out_tag`=0, `out_illegal`=0; `in_ready`=1 once reset is released.
- Formats; `i` denotes `in_instr` bit at its original instruction index; `sext`/`zext` extend to `XLEN`:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - SB: sext({i[31], i[7], i[30:25], i[11:8], 0}).
  - UJ: sext({i[31], i[19:12], i[20], i[30:21], 0}).
  - U: sext({i[31:12], 12'b0}); for `XLEN`=64, bits 63:32 copy i[31].
  - Z: zext(i[19:15]).
  - SHAMT: zext(i[25:20]) if `XLEN`=64, else zext(i[24:20]).
  - sel 7: imm=0, `out_illegal`=1.
- Handshake:
  - Transfer in when `in_valid` && `in_ready`; transfer out when `out_valid` && `out_ready`.
  - `out_valid` must stay high and `out_imm`/`out_tag`/`out_illegal` must stay stable until accepted.
- Latency: an accepted request appears on the outputs the next cycle when the output entry is empty or drains that cycle.
- Storage states: EMPTY (nothing held), ONE (main entry valid), TWO (main + skid valid).
  - EMPTY: in-transfer → ONE.
  - ONE: in without out → TWO (request lands in skid); out without in → EMPTY; in and out together → ONE with new data; neither → hold.
  - TWO: out → ONE, with skid moved to main; no out → hold.
- `in_ready` = !skid_valid; it is registered and has no combinational path from `out_ready`.
- Throughput: one result per cycle sustained while `out_ready`=1.
- Order: strict FIFO; results are never reordered or dropped except by flush.
- `flush`=1: next cycle → EMPTY, `out_valid`=0. An input transfer in the same cycle is discarded. Flush overrides everything except reset. Data registers may keep stale values, but `out_valid`=0.
- Reset mid-operation: immediate return to EMPTY; no partial results.
- Width rules: all arithmetic is pure bit selection and extension; no truncation for either `XLEN`.

Test Plan:
- `XLEN`=32, sel I, instr 0xFFF00093, `out_ready`=1 → next cycle `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_illegal`=0.
- sel SB, instr 0xFE000EE3 (beq −4) → 0xFFFFFFFC; sel U, instr 0x123450B7 → 0x12345000; sel Z with i[19:15]=5'b11111 → 0x0000001F.
- `XLEN`=64: sel U, instr 0x800000B7 → 0xFFFFFFFF80000000; sel SHAMT, i[25:20]=6'h3F → 0x3F. The same SHAMT input at `XLEN`=32 → 0x1F.
- Backpressure: issue tags 1,2,3 back-to-back with `out_ready`=0:
  - `in_ready` drops after the second accept; the third request is held upstream.
  - Raise `out_ready`: tags emerge in order 1,2,3, outputs stable while stalled, no loss or duplication.
- Flush in TWO state with a simultaneous `in_valid` → next cycle `out_valid`=0, `in_ready`=1, none of the three tags ever appear.
- sel 7 → `out_imm`=0, `out_illegal`=1; assert `rst_n`=0 while in TWO → outputs zero asynchronously; after release `in_ready`=1 and `out_valid`=0.
